line_fetch_addr_gen: RTL

LINE_FETCH_ADDR_GEN -- requirements
Module: line_fetch_addr_gen

---
 rtl/line_fetch_pkg.sv | 22 ++
 rtl/line_fetch_trig_table.sv | 45 ++++
 rtl/line_fetch_addr_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/line_fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | line_fetch_pkg : read-FSM state encoding and default parameters       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package line_fetch_pkg;

  localparam int c_DEF_WR_AW    = 11;
  localparam int c_DEF_WR_DEPTH = 1600;
  localparam int c_DEF_RD_AW    = 10;
  localparam int c_DEF_OFS_W    = 7;
  localparam int c_DEF_N_TRIG   = 10;
  localparam int c_DEF_CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/line_fetch_trig_table.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | line_fetch_trig_table : trigger-slot register file + parallel compare |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module line_fetch_trig_table
  import line_fetch_pkg::*;
#(
  parameter int N_TRIG = c_DEF_N_TRIG,
  parameter int RD_AW  = c_DEF_RD_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [$clog2(N_TRIG)-1:0] i_idx,
  input  logic [RD_AW-1:0]          i_waddr,
  input  logic                      i_vld,
  input  logic [RD_AW-1:0]          i_cmp_addr,
  output logic                      o_hit
);

  logic [N_TRIG-1:0] w_match;

  // Out-of-range indices select no slot, so such writes fall away naturally.
  for (genvar g = 0; g < N_TRIG; g++) begin : g_slot
    logic             r_vld;
    logic [RD_AW-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_addr <= '0;
      end else if (i_we && (32'(i_idx) == g)) begin
        r_vld  <= i_vld;
        r_addr <= i_waddr;
      end
    end

    assign w_match[g] = r_vld && (r_addr == i_cmp_addr);
  end

  assign o_hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/line_fetch_addr_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | line_fetch_addr_gen : write/read line address generator with trigger  |
// | driven request counter.  Rev 1.0                                      |
// +-----------------------------------------------------------------------+
module line_fetch_addr_gen
  import line_fetch_pkg::*;
#(
  parameter int WR_AW    = c_DEF_WR_AW,
  parameter int WR_DEPTH = c_DEF_WR_DEPTH,
  parameter int RD_AW    = c_DEF_RD_AW,
  parameter int OFS_W    = c_DEF_OFS_W,
  parameter int N_TRIG   = c_DEF_N_TRIG,
  parameter int CNT_W    = c_DEF_CNT_W
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic                      iEN_W,
  input  logic                      iEN_PERIOD,
  input  logic                      iEN_R,
  input  logic                      iMODE_WRAP,
  input  logic [RD_AW-1:0]          iREG_WIDTH,
  input  logic [OFS_W-1:0]          iREG_OFFSET,
  input  logic                      iTRIG_WE,
  input  logic [$clog2(N_TRIG)-1:0] iTRIG_IDX,
  input  logic [RD_AW-1:0]          iTRIG_ADDR,
  input  logic                      iTRIG_VLD,
  input  logic                      iREQ_CLR,
  output logic [WR_AW-1:0]          oADDR_W,
  output logic [RD_AW-1:0]          oADDR_R,
  output logic                      oREQ_W,
  output logic [CNT_W-1:0]          oPEND,
  output logic                      oOVF,
  output logic                      oLINE_DONE
);

  logic [WR_AW-1:0] r_addr_w;
  logic [RD_AW-1:0] r_addr_r;
  rd_state_e        r_state;
  logic             r_line_done;
  logic [CNT_W-1:0] r_pend;
  logic             r_req;
  logic             r_ovf;

  logic [RD_AW-1:0] w_start;
  logic [RD_AW-1:0] w_last;
  logic             w_at_last;
  logic             w_adv;
  logic             w_hit;
  logic             w_event;
  logic             w_clr;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_ovf_set;

  // ---------------- write address ----------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_addr_w <= '0;
    end else if (iEN_W) begin
      r_addr_w <= (r_addr_w == WR_AW'(WR_DEPTH - 1)) ? '0 : r_addr_w + WR_AW'(1);
    end
  end

  // ---------------- read address / FSM ----------------
  assign w_start   = RD_AW'({iREG_OFFSET, 1'b0});
  // A zero width behaves as a one-pixel line.
  assign w_last    = (iREG_WIDTH == '0) ? '0 : iREG_WIDTH - RD_AW'(1);
  assign w_at_last = (r_addr_r == w_last);
  assign w_adv     = iEN_PERIOD && iEN_R && (r_state == ST_ACTIVE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_addr_r    <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= w_adv && w_at_last;
      if (!iEN_PERIOD) begin
        r_state  <= ST_IDLE;
        r_addr_r <= w_start;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_ACTIVE;
            r_addr_r <= w_start;
          end
          ST_ACTIVE: begin
            if (iEN_R) begin
              if (w_at_last) begin
                if (iMODE_WRAP) begin
                  r_addr_r <= w_start;
                end else begin
                  r_state <= ST_HOLD;
                end
              end else begin
                r_addr_r <= r_addr_r + RD_AW'(1);
              end
            end
          end
          ST_HOLD: begin
            r_state <= ST_HOLD;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_addr_r <= w_start;
          end
        endcase
      end
    end
  end

  // ---------------- trigger detection ----------------
  line_fetch_trig_table #(
    .N_TRIG (N_TRIG),
    .RD_AW  (RD_AW)
  ) u_trig_table (
    .clk        (iCLK),
    .rst_n      (iRST_N),
    .i_we       (iTRIG_WE),
    .i_idx      (iTRIG_IDX),
    .i_waddr    (iTRIG_ADDR),
    .i_vld      (iTRIG_VLD),
    .i_cmp_addr (r_addr_r),
    .o_hit      (w_hit)
  );

  assign w_event = w_adv && (w_at_last || w_hit);

  // ---------------- pending request counter ----------------
  assign w_clr = iREQ_CLR && (r_pend != '0);

  // A clear absorbs a coincident event, so only an unabsorbed event can overflow.
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_set  = 1'b0;
    if (w_event && !w_clr) begin
      if (r_pend == '1) begin
        w_ovf_set = 1'b1;
      end else begin
        w_pend_nxt = r_pend + CNT_W'(1);
      end
    end else if (!w_event && w_clr) begin
      w_pend_nxt = r_pend - CNT_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_pend <= '0;
      r_req  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_req  <= (w_pend_nxt != '0);
      r_ovf  <= r_ovf || w_ovf_set;
    end
  end

  assign oADDR_W    = r_addr_w;
  assign oADDR_R    = r_addr_r;
  assign oREQ_W     = r_req;
  assign oPEND      = r_pend;
  assign oOVF       = r_ovf;
  assign oLINE_DONE = r_line_done;

endmodule
`default_nettype wire
